// File: rtl/approx_acc_pkg.sv
// Shared types and default sizing for the approximate-product accumulator.
package approx_acc_pkg;

    localparam int DEF_PROD_W = 16;
    localparam int DEF_ACC_W  = 24;
    localparam int DEF_LEN    = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } acc_state_e;

endpackage

// File: rtl/approx_prod_accumulator_if.sv
// Product stream in, result stream out, plus the clear line and the multiplier enable.
// The slave side is the accumulator; the master side is the surrounding logic.
interface approx_prod_accumulator_if
    import approx_acc_pkg::*;
#(
    parameter int PROD_W = DEF_PROD_W,
    parameter int ACC_W  = DEF_ACC_W
);
    logic              clr;
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_prod;
    logic              mult_en;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic              out_ovf;

    modport master (
        output clr, in_valid, in_prod, out_ready,
        input  in_ready, mult_en, out_valid, out_sum, out_ovf
    );

    modport slave (
        input  clr, in_valid, in_prod, out_ready,
        output in_ready, mult_en, out_valid, out_sum, out_ovf
    );
endinterface

// File: rtl/approx_acc_add.sv
// Accumulator adder: acc + zero-extended product with carry out.
// Build option ACC_SATURATE_EN: clamp to all-ones on carry instead of wrapping.
// A clamped sum stays all-ones, since any further non-zero add carries again.
module approx_acc_add
    import approx_acc_pkg::*;
#(
    parameter int PROD_W = DEF_PROD_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] prod,
    output logic [ACC_W-1:0]  sum,
    output logic              carry
);
    logic [ACC_W:0] full;

    // Full-width add, then wrap or saturate the low ACC_W bits.
    always_comb begin
        full  = {1'b0, acc} + {1'b0, ACC_W'(prod)};
        carry = full[ACC_W];
`ifdef ACC_SATURATE_EN
        sum   = carry ? '1 : full[ACC_W-1:0];
`else
        sum   = full[ACC_W-1:0];
`endif
    end
endmodule

// File: rtl/approx_prod_accumulator.sv
// Sums LEN approximate products into one result and hands it on via valid/ready.
// mult_en mirrors in_ready so the upstream multiplier only toggles when a product
// can be consumed. Optional build macro ACC_SATURATE_EN (see approx_acc_add).
//
//  state | meaning
//  IDLE  | waiting for the first product of a result
//  ACCUM | summing products 2..LEN
//  HOLD  | result presented on out_sum/out_ovf, input stalled
module approx_prod_accumulator
    import approx_acc_pkg::*;
#(
    parameter int PROD_W = DEF_PROD_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int LEN    = DEF_LEN
) (
    input logic                       clk,
    input logic                       rst,
    approx_prod_accumulator_if.slave  bus
);
    localparam int CNT_W = $clog2(LEN + 1);

    acc_state_e       state, state_nxt;
    logic [ACC_W-1:0] acc, acc_nxt, add_a, add_sum;
    logic             add_carry;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
    logic             ovf, ovf_nxt;
    logic             ready;
    logic             accept;

    assign ready   = (state != HOLD);
    assign accept  = bus.in_valid & ready;
    assign cnt_inc = cnt + CNT_W'(1);
    // The first product of a result loads rather than adds.
    assign add_a   = (state == IDLE) ? '0 : acc;

    approx_acc_add #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W)
    ) u_add (
        .acc   (add_a),
        .prod  (bus.in_prod),
        .sum   (add_sum),
        .carry (add_carry)
    );

    // Next-state and datapath update; clr overrides everything but reset.
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        ovf_nxt   = ovf;
        case (state)
            IDLE: begin
                if (accept) begin
                    acc_nxt   = add_sum;
                    cnt_nxt   = CNT_W'(1);
                    ovf_nxt   = 1'b0;
                    state_nxt = (LEN == 1) ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    acc_nxt = add_sum;
                    cnt_nxt = cnt_inc;
                    ovf_nxt = ovf | add_carry;
                    if (cnt_inc == CNT_W'(LEN)) begin
                        state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                    acc_nxt   = '0;
                    cnt_nxt   = '0;
                    ovf_nxt   = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
                acc_nxt   = '0;
                cnt_nxt   = '0;
                ovf_nxt   = 1'b0;
            end
        endcase
        if (bus.clr) begin
            state_nxt = IDLE;
            acc_nxt   = '0;
            cnt_nxt   = '0;
            ovf_nxt   = 1'b0;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
            ovf   <= ovf_nxt;
        end
    end

    assign bus.in_ready  = ready;
    assign bus.mult_en   = ready;
    assign bus.out_valid = (state == HOLD);
    assign bus.out_sum   = acc;
    assign bus.out_ovf   = ovf;
endmodule

// File: tb/tb_approx_prod_accumulator.sv
// Self-checking bench: directed tables/sequences on three parameterisations,
// then random traffic against a sum-of-accepted-products reference model.
module tb_approx_prod_accumulator;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_mis = 0;

    always #5 clk = ~clk;

    approx_prod_accumulator_if #(.PROD_W(16), .ACC_W(24)) if8 ();
    approx_prod_accumulator_if #(.PROD_W(16), .ACC_W(16)) if2 ();
    approx_prod_accumulator_if #(.PROD_W(16), .ACC_W(24)) if1 ();

    approx_prod_accumulator #(.PROD_W(16), .ACC_W(24), .LEN(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));
    approx_prod_accumulator #(.PROD_W(16), .ACC_W(16), .LEN(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));
    approx_prod_accumulator #(.PROD_W(16), .ACC_W(24), .LEN(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

    typedef struct {
        logic [15:0] prod;
        logic [23:0] sum;
        logic        ovf;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        if8.clr = 0; if8.in_valid = 0; if8.in_prod = 0; if8.out_ready = 0;
        if2.clr = 0; if2.in_valid = 0; if2.in_prod = 0; if2.out_ready = 0;
        if1.clr = 0; if1.in_valid = 0; if1.in_prod = 0; if1.out_ready = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic chk_reset8(input string tag);
        chk({tag, "_out_valid"}, 32'(if8.out_valid), 32'd0);
        chk({tag, "_out_sum"},   32'(if8.out_sum),   32'd0);
        chk({tag, "_in_ready"},  32'(if8.in_ready),  32'd1);
        chk({tag, "_out_ovf"},   32'(if8.out_ovf),   32'd0);
    endtask

    // Push n products of value p into dut8 back-to-back.
    task automatic push8(input int n, input logic [15:0] p);
        if8.in_valid = 1'b1;
        if8.in_prod  = p;
        for (int i = 0; i < n; i++) step();
        if8.in_valid = 1'b0;
    endtask

    // Reference model state for the random phase: index 0 = dut8, 1 = dut2.
    int     m_len [2] = '{8, 2};
    int     m_w   [2] = '{24, 16};
    bit     m_pend[2];
    longint m_tot [2];
    int     m_n   [2];

    task automatic model_check(input int k, input logic rdy, input logic men, input logic ov_v,
                               input logic [31:0] sum, input logic ov);
        longint maxv;
        longint es;
        maxv = (longint'(1) << m_w[k]) - 1;
`ifdef ACC_SATURATE_EN
        es = (m_tot[k] > maxv) ? maxv : m_tot[k];
`else
        es = m_tot[k] & maxv;
`endif
        chk($sformatf("rnd%0d_in_ready", k),  32'(rdy),  32'(!m_pend[k]));
        chk($sformatf("rnd%0d_mult_en", k),   32'(men),  32'(!m_pend[k]));
        chk($sformatf("rnd%0d_out_valid", k), 32'(ov_v), 32'(m_pend[k]));
        if (m_pend[k]) begin
            chk($sformatf("rnd%0d_out_sum", k), sum, 32'(es));
            chk($sformatf("rnd%0d_out_ovf", k), 32'(ov), 32'(m_tot[k] > maxv));
        end
    endtask

    task automatic model_update(input int k, input bit c, input bit v, input logic [15:0] p, input bit r);
        if (c) begin
            m_pend[k] = 0; m_tot[k] = 0; m_n[k] = 0;
        end else if (m_pend[k]) begin
            if (r) begin
                m_pend[k] = 0; m_tot[k] = 0; m_n[k] = 0;
            end
        end else if (v) begin
            m_tot[k] += longint'(p);
            m_n[k]++;
            if (m_n[k] == m_len[k]) m_pend[k] = 1;
        end
    endtask

    initial begin
        vec_t tbl[5];
        int   acc_cnt;
        bit   rv, rc, rr;
        logic [15:0] rp;

        tbl[0] = '{16'h1234, 24'h001234, 1'b0};
        tbl[1] = '{16'h0000, 24'h000000, 1'b0};
        tbl[2] = '{16'hFFFF, 24'h00FFFF, 1'b0};
        tbl[3] = '{16'h8001, 24'h008001, 1'b0};
        tbl[4] = '{16'h0001, 24'h000001, 1'b0};

        idle_all();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk_reset8("reset");

        // 1: eight back-to-back 0x0100 products
        if8.in_valid = 1'b1;
        if8.in_prod  = 16'h0100;
        for (int i = 0; i < 8; i++) begin
            step();
            chk($sformatf("t1_out_valid_%0d", i), 32'(if8.out_valid), 32'(i == 7));
        end
        if8.in_valid = 1'b0;
        chk("t1_out_sum", 32'(if8.out_sum), 32'h000800);
        chk("t1_out_ovf", 32'(if8.out_ovf), 32'd0);
        if8.out_ready = 1'b1;
        step();
        if8.out_ready = 1'b0;
        chk("t1_idle_valid", 32'(if8.out_valid), 32'd0);

        // 2: gapped input, stalled output
        acc_cnt = 0;
        if8.in_prod = 16'h0100;
        for (int i = 0; i < 16; i++) begin
            if8.in_valid = (i % 2 == 0);
            if ((i % 2 == 0) && acc_cnt < 8) acc_cnt++;
            step();
            chk($sformatf("t2_out_valid_%0d", i), 32'(if8.out_valid), 32'(acc_cnt == 8));
        end
        if8.in_valid = 1'b1;
        if8.in_prod  = 16'h5555;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t2_hold_in_ready", 32'(if8.in_ready),  32'd0);
            chk("t2_hold_mult_en",  32'(if8.mult_en),   32'd0);
            chk("t2_hold_valid",    32'(if8.out_valid), 32'd1);
            chk("t2_hold_sum",      32'(if8.out_sum),   32'h000800);
        end
        if8.in_valid  = 1'b0;
        if8.out_ready = 1'b1;
        step();
        if8.out_ready = 1'b0;
        chk("t2_after_valid", 32'(if8.out_valid), 32'd0);
        chk("t2_after_ready", 32'(if8.in_ready),  32'd1);
        chk("t2_after_sum",   32'(if8.out_sum),   32'd0);

        // 3: wrap/saturate on ACC_W=16, LEN=2
        if2.in_valid = 1'b1;
        if2.in_prod  = 16'hFFFF;
        step();
        if2.in_prod  = 16'h0002;
        step();
        if2.in_valid = 1'b0;
        chk("t3_out_valid", 32'(if2.out_valid), 32'd1);
`ifdef ACC_SATURATE_EN
        chk("t3_out_sum", 32'(if2.out_sum), 32'h0000FFFF);
`else
        chk("t3_out_sum", 32'(if2.out_sum), 32'h00000001);
`endif
        chk("t3_out_ovf", 32'(if2.out_ovf), 32'd1);
        if2.out_ready = 1'b1;
        step();
        if2.out_ready = 1'b0;

        // 4: clr with a sample on the 4th product
        push8(3, 16'h0001);
        if8.in_valid = 1'b1;
        if8.clr      = 1'b1;
        #1;
        chk("t4_clr_in_ready", 32'(if8.in_ready), 32'd1);
        step();
        if8.clr      = 1'b0;
        if8.in_valid = 1'b0;
        chk("t4_clr_sum",   32'(if8.out_sum),   32'd0);
        chk("t4_clr_valid", 32'(if8.out_valid), 32'd0);
        push8(7, 16'h0001);
        chk("t4_7_valid", 32'(if8.out_valid), 32'd0);
        push8(1, 16'h0001);
        chk("t4_valid", 32'(if8.out_valid), 32'd1);
        chk("t4_sum",   32'(if8.out_sum),   32'd8);
        // clr in HOLD beats out_ready
        if8.clr       = 1'b1;
        if8.out_ready = 1'b1;
        step();
        if8.clr       = 1'b0;
        if8.out_ready = 1'b0;
        chk("t4_hold_clr_valid", 32'(if8.out_valid), 32'd0);
        chk("t4_hold_clr_sum",   32'(if8.out_sum),   32'd0);

        // 5: reset in ACCUM and in HOLD
        push8(3, 16'h0077);
        do_reset();
        chk_reset8("t5_accum");
        push8(8, 16'h0077);
        chk("t5_hold_reached", 32'(if8.out_valid), 32'd1);
        do_reset();
        chk_reset8("t5_hold");

        // 6: LEN=1 table, out_ready tied high, in_valid held high
        if1.out_ready = 1'b1;
        if1.in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if1.in_prod = tbl[i].prod;
            step();
            chk($sformatf("t6_valid_%0d", i), 32'(if1.out_valid), 32'd1);
            chk($sformatf("t6_ready_%0d", i), 32'(if1.in_ready),  32'd0);
            chk($sformatf("t6_sum_%0d", i),   32'(if1.out_sum),   32'(tbl[i].sum));
            chk($sformatf("t6_ovf_%0d", i),   32'(if1.out_ovf),   32'(tbl[i].ovf));
            step();
            chk($sformatf("t6_idle_%0d", i),  32'(if1.out_valid), 32'd0);
            chk($sformatf("t6_rdy_%0d", i),   32'(if1.in_ready),  32'd1);
        end
        idle_all();

        // Random traffic on dut8 and dut2 with identical stimulus.
        do_reset();
        for (int k = 0; k < 2; k++) begin
            m_pend[k] = 0; m_tot[k] = 0; m_n[k] = 0;
        end
        for (int cyc = 0; cyc < 1500; cyc++) begin
            model_check(0, if8.in_ready, if8.mult_en, if8.out_valid, 32'(if8.out_sum), if8.out_ovf);
            model_check(1, if2.in_ready, if2.mult_en, if2.out_valid, 32'(if2.out_sum), if2.out_ovf);
            rv = ($urandom_range(0, 99) < 70);
            rc = ($urandom_range(0, 63) == 0);
            rr = ($urandom_range(0, 99) < 50);
            rp = 16'($urandom);
            if8.in_valid = rv; if8.clr = rc; if8.out_ready = rr; if8.in_prod = rp;
            if2.in_valid = rv; if2.clr = rc; if2.out_ready = rr; if2.in_prod = rp;
            model_update(0, rc, rv, rp, rr);
            model_update(1, rc, rv, rp, rr);
            step();
        end
        idle_all();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
